id_stage_regfile_pipe: RTL and testbench

- Parametrised decode-stage core for the five-stage MIPS pipeline.
- Contains the GRF (general register file) with a configurable number of read ports, internal write-through bypass and external M/W forwarding muxes.
- Includes a signed branch comparator with a branch/jump target adder.
- Adds a D/E pipeline register with stall, flush and hold control. The block sits between the F/D register and the Execute stage.

---
 rtl/id_stage_regfile_pipe.sv | 108 ++++++++++
 tb/tb_id_stage_regfile_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage_regfile_pipe.sv
// id_stage_regfile_pipe: MIPS decode stage with GRF, forwarding, branch compare and D/E register.
// Optional stall counter output enabled by defining ID_STALL_CNT_EN.
module id_stage_regfile_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  d_instr,
    input  logic [31:0]                  d_pc,
    input  logic                         d_valid,
    input  logic [5*RD_PORTS-1:0]        raddr,
    input  logic [2*RD_PORTS-1:0]        fwd_sel,
    input  logic [DATA_W-1:0]            m_fwd,
    input  logic [DATA_W-1:0]            w_fwd,
    input  logic                         we,
    input  logic [4:0]                   waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [2:0]                   br_mode,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         e_hold,
    output logic [DATA_W*RD_PORTS-1:0]   rdata,
    output logic                         br_taken,
    output logic [31:0]                  br_target,
    output logic [DATA_W*RD_PORTS-1:0]   e_rdata,
    output logic [31:0]                  e_instr,
    output logic [31:0]                  e_pc,
    output logic                         e_valid
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);
    logic [DATA_W-1:0] grf [REG_NUM];
    logic              w_ok;
    logic              bubble;
    logic              cmp;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [31:0]       off;

    assign w_ok = we && waddr != 5'd0 && {1'b0, waddr} < 6'(REG_NUM);

    always_ff @(posedge clk) begin
        if (reset)
            for (int i = 0; i < REG_NUM; i++) grf[i] <= '0;
        else if (w_ok)
            grf[waddr] <= wdata;
    end

    // Forward muxes win over the same-cycle write-through bypass.
    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [4:0] ra;
        logic [1:0] fs;
        logic       ok;
        assign ra = raddr[5*k +: 5];
        assign fs = fwd_sel[2*k +: 2];
        assign ok = ra != 5'd0 && {1'b0, ra} < 6'(REG_NUM);
        assign rdata[DATA_W*k +: DATA_W] = fs == 2'b10 ? m_fwd :
                                           fs == 2'b01 ? w_fwd :
                                           !ok ? '0 :
                                           (w_ok && waddr == ra) ? wdata : grf[ra];
    end

    assign a   = rdata[DATA_W-1:0];
    assign b   = rdata[2*DATA_W-1:DATA_W];
    assign off = {{14{d_instr[15]}}, d_instr[15:0], 2'b00};

    // Signed zero compares reduce to sign bit and zero test.
    always_comb begin
        cmp = br_mode == 3'd1 ? a == b :
              br_mode == 3'd2 ? a != b :
              br_mode == 3'd3 ? a[DATA_W-1] || a == '0 :
              br_mode == 3'd4 ? !a[DATA_W-1] && a != '0 :
              br_mode == 3'd5 ? a[DATA_W-1] :
              br_mode == 3'd6 ? !a[DATA_W-1] :
              br_mode == 3'd7;
        br_taken  = d_valid && cmp;
        br_target = br_mode == 3'd7 ? 32'(a) : d_pc + 32'd4 + off;
    end

    assign bubble = stall || flush || !d_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid <= 1'b0;
            e_instr <= '0;
            e_pc    <= '0;
            e_rdata <= '0;
        end else if (!e_hold) begin
            e_valid <= !bubble;
            e_instr <= bubble ? '0 : d_instr;
            e_pc    <= bubble ? '0 : d_pc;
            e_rdata <= bubble ? '0 : rdata;
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && !e_hold && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_id_stage_regfile_pipe.sv
// tb_id_stage_regfile_pipe: scoreboard bench with a behavioural register-file/branch/pipeline model.
module tb_id_stage_regfile_pipe;
    logic        clk = 0;
    logic        reset = 1;
    logic [31:0] d_instr = 0, d_pc = 0;
    logic        d_valid = 0;
    logic [9:0]  raddr = 0;
    logic [3:0]  fwd_sel = 0;
    logic [31:0] m_fwd = 0, w_fwd = 0, wdata = 0;
    logic        we = 0;
    logic [4:0]  waddr = 0;
    logic [2:0]  br_mode = 0;
    logic        stall = 0, flush = 0, e_hold = 0;
    logic [63:0] rdata, e_rdata;
    logic        br_taken, e_valid;
    logic [31:0] br_target, e_instr, e_pc;
    logic [31:0] cnt_obs;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
    assign cnt_obs = stall_cnt;
`else
    assign cnt_obs = 0;
`endif

    id_stage_regfile_pipe dut (
        .clk(clk), .reset(reset), .d_instr(d_instr), .d_pc(d_pc), .d_valid(d_valid),
        .raddr(raddr), .fwd_sel(fwd_sel), .m_fwd(m_fwd), .w_fwd(w_fwd),
        .we(we), .waddr(waddr), .wdata(wdata), .br_mode(br_mode),
        .stall(stall), .flush(flush), .e_hold(e_hold),
        .rdata(rdata), .br_taken(br_taken), .br_target(br_target),
        .e_rdata(e_rdata), .e_instr(e_instr), .e_pc(e_pc), .e_valid(e_valid)
`ifdef ID_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] rd; logic tk; logic [31:0] tg; } cexp_t;
    typedef struct { logic v; logic [31:0] i; logic [31:0] p; logic [63:0] rd; logic [31:0] cnt; } eexp_t;

    cexp_t       cq[$];
    eexp_t       eq[$];
    logic [31:0] mgrf [32];
    eexp_t       me;
    logic [31:0] mcnt;
    int          checks = 0, errors = 0;

    function automatic logic [31:0] model_rd(input int port);
        int a = int'(raddr[5*port +: 5]);
        logic [1:0] s = fwd_sel[2*port +: 2];
        if (s == 2) return m_fwd;
        if (s == 1) return w_fwd;
        if (a == 0) return 0;
        if (we && int'(waddr) == a) return wdata;
        return mgrf[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        reset = 0; we = 0; stall = 0; flush = 0; e_hold = 0; br_mode = 0;
        fwd_sel = 0; d_valid = 1;
    endtask

    // Compute expectations for the inputs of this cycle, then advance the model past the edge.
    task automatic commit();
        logic [31:0] a, b, tg;
        logic signed [31:0] sa, imm;
        logic tk;
        #1;
        a = model_rd(0); b = model_rd(1); sa = a;
        imm = 32'($signed(d_instr[15:0]));
        case (br_mode)
            1: tk = a == b;
            2: tk = a != b;
            3: tk = sa <= 0;
            4: tk = sa > 0;
            5: tk = sa < 0;
            6: tk = sa >= 0;
            7: tk = 1;
            default: tk = 0;
        endcase
        tk = tk && d_valid;
        tg = br_mode == 7 ? a : d_pc + 4 + imm * 4;
        cq.push_back('{{b, a}, tk, tg});
        if (reset) begin
            for (int i = 0; i < 32; i++) mgrf[i] = 0;
            me = '{0, 0, 0, 0, 0};
            mcnt = 0;
        end else begin
            if (we && waddr != 0) mgrf[waddr] = wdata;
            if (!e_hold) begin
                if (stall || flush || !d_valid) me = '{0, 0, 0, 0, 0};
                else me = '{1, d_instr, d_pc, {b, a}, 0};
                if (stall && mcnt != 32'hFFFF_FFFF) mcnt++;
            end
        end
        me.cnt = mcnt;
        eq.push_back(me);
    endtask

    initial forever begin
        cexp_t c;
        @(negedge clk); #2;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("rdata", rdata, c.rd);
            chk("br_taken", {63'b0, br_taken}, {63'b0, c.tk});
            if (c.tk) chk("br_target", {32'b0, br_target}, {32'b0, c.tg});
        end
    end

    initial forever begin
        eexp_t e;
        @(posedge clk); #1;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("e_valid", {63'b0, e_valid}, {63'b0, e.v});
            chk("e_instr", {32'b0, e_instr}, {32'b0, e.i});
            chk("e_pc", {32'b0, e_pc}, {32'b0, e.p});
            chk("e_rdata", e_rdata, e.rd);
`ifdef ID_STALL_CNT_EN
            chk("stall_cnt", {32'b0, cnt_obs}, {32'b0, e.cnt});
`endif
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mgrf[i] = 0;
        mcnt = 0;
        nxt(); reset = 1; commit();
        nxt(); reset = 1; commit();
        // write-through bypass, then stored value
        nxt(); we = 1; waddr = 5; wdata = 32'h1234; raddr = {5'd0, 5'd5}; commit();
        nxt(); raddr = {5'd0, 5'd5}; commit();
        // register 0 ignores writes
        nxt(); we = 1; waddr = 0; wdata = 32'hFFFF_FFFF; raddr = 0; commit();
        nxt(); raddr = 0; commit();
        // forward priority
        nxt(); we = 1; waddr = 3; wdata = 7; commit();
        nxt(); m_fwd = 9; w_fwd = 8; raddr = {5'd0, 5'd3}; fwd_sel = 4'b0010; commit();
        nxt(); raddr = {5'd0, 5'd3}; fwd_sel = 4'b0001; commit();
        nxt(); raddr = {5'd0, 5'd3}; fwd_sel = 4'b0011; commit();
        // branches
        nxt(); we = 1; waddr = 1; wdata = 4; commit();
        nxt(); we = 1; waddr = 2; wdata = 4; commit();
        nxt(); raddr = {5'd2, 5'd1}; d_pc = 32'h3000; d_instr = 32'h1000_FFFF; br_mode = 1; commit();
        nxt(); m_fwd = 32'h8000_0000; fwd_sel = 4'b0010; br_mode = 5; commit();
        nxt(); m_fwd = 32'h3050; fwd_sel = 4'b0010; br_mode = 7; commit();
        nxt(); m_fwd = 32'h3050; fwd_sel = 4'b0010; br_mode = 7; d_valid = 0; commit();
        // pipeline control
        nxt(); d_instr = 32'h0043_2020; d_pc = 32'h400; raddr = {5'd2, 5'd3}; commit();
        nxt(); d_instr = 32'h1111_1111; e_hold = 1; flush = 1; commit();
        nxt(); flush = 1; commit();
        // stall counter and hold gating
        nxt(); reset = 1; commit();
        repeat (3) begin nxt(); stall = 1; commit(); end
        nxt(); stall = 1; e_hold = 1; commit();
        nxt(); commit();
        // randomized traffic
        repeat (400) begin
            nxt();
            reset   = $urandom_range(0, 60) == 0;
            d_instr = $urandom; d_pc = $urandom;
            d_valid = $urandom_range(0, 5) != 0;
            raddr   = 10'($urandom); fwd_sel = 4'($urandom);
            m_fwd   = $urandom_range(0, 3) == 0 ? 0 : $urandom;
            w_fwd   = $urandom;
            we      = $urandom_range(0, 2) != 0; waddr = 5'($urandom); wdata = $urandom;
            br_mode = 3'($urandom);
            stall   = $urandom_range(0, 4) == 0; flush = $urandom_range(0, 6) == 0;
            e_hold  = $urandom_range(0, 5) == 0;
            commit();
        end
        nxt(); commit();
        repeat (3) @(negedge clk);
        if (cq.size() != 0 || eq.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d/%0d required=0/0", cq.size(), eq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
